// File: rtl/stage_if.sv
// stage_if: instruction-fetch stage that owns the PC.
// Each 32-bit instruction is assembled from four little-endian byte reads
// through the memory controller's byte port. The stage presents pc/inst with a
// valid flag to the IF/ID register and accepts taken-branch redirects from decode.
// Optional build macro ICACHE_EN adds a direct-mapped icache with
// 2^ICACHE_IDX_W lines of one instruction each.
//
// state   | meaning
// S_FETCH | requesting bytes fetch_pc+cnt (or checking the icache for a hit)
// S_HOLD  | instruction presented on pc_o/inst_o, waiting for IF/ID to take it
module stage_if #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          ICACHE_IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall_i,
  input  logic        branch_enable_i,
  input  logic [31:0] branch_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic {S_FETCH = 1'b0, S_HOLD = 1'b1} state_t;

  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [23:0] part, part_n;
  logic [31:0] pc_n, inst_n, addr_n;
  logic        valid_n, req_n;
  logic        redirect, ack_ok, fill;
  logic [31:0] seq_pc;
  logic        hit_cur, hit_seq;
  logic [31:0] hit_data;

  // Decode only redirects once its operands are final (no stall pending).
  assign redirect = branch_enable_i && !stall_i;
  // An ack only counts while a request is actually outstanding.
  assign ack_ok   = (state == S_FETCH) && mem_req_o && mem_ack_i;
  assign seq_pc   = fetch_pc + 32'd4;

`ifdef ICACHE_EN
  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 30 - ICACHE_IDX_W;

  logic [LINES-1:0]        line_valid;
  logic [TAG_W-1:0]        line_tag  [LINES];
  logic [31:0]             line_data [LINES];
  logic [ICACHE_IDX_W-1:0] idx_cur, idx_seq;

  assign idx_cur  = fetch_pc[ICACHE_IDX_W+1:2];
  assign idx_seq  = seq_pc[ICACHE_IDX_W+1:2];
  assign hit_cur  = line_valid[idx_cur] &&
                    (line_tag[idx_cur] == fetch_pc[31:ICACHE_IDX_W+2]);
  assign hit_seq  = line_valid[idx_seq] &&
                    (line_tag[idx_seq] == seq_pc[31:ICACHE_IDX_W+2]);
  assign hit_data = line_data[idx_cur];

  // Line valid bits; cleared on reset, set when a fill completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_valid <= '0;
    end else if (rdy && fill) begin
      line_valid[idx_cur] <= 1'b1;
    end
  end

  // Tag and data storage need no reset; they are qualified by line_valid.
  always_ff @(posedge clk) begin
    if (rdy && fill) begin
      line_tag[idx_cur]  <= fetch_pc[31:ICACHE_IDX_W+2];
      line_data[idx_cur] <= {mem_data_i, part};
    end
  end
`else
  // Keeps the index width parameter referenced in the cacheless build.
  logic [ICACHE_IDX_W-1:0] idx_unused;
  assign idx_unused = fetch_pc[ICACHE_IDX_W+1:2];
  assign hit_cur    = 1'b0;
  assign hit_seq    = 1'b0;
  assign hit_data   = 32'h0;
`endif

  // Next-state and next-output logic; a redirect outranks every other event.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    fetch_pc_n = fetch_pc;
    part_n     = part;
    pc_n       = pc_o;
    inst_n     = inst_o;
    valid_n    = inst_valid_o;
    req_n      = mem_req_o;
    addr_n     = mem_addr_o;
    fill       = 1'b0;
    if (redirect) begin
      // Request drops for one cycle; any ack this cycle and the partial word are lost.
      state_n    = S_FETCH;
      cnt_n      = 2'd0;
      fetch_pc_n = branch_addr_i;
      valid_n    = 1'b0;
      req_n      = 1'b0;
      addr_n     = branch_addr_i;
    end else begin
      case (state)
        S_FETCH: begin
          if (hit_cur && (cnt == 2'd0)) begin
            state_n = S_HOLD;
            pc_n    = fetch_pc;
            inst_n  = hit_data;
            valid_n = 1'b1;
            req_n   = 1'b0;
          end else if (ack_ok) begin
            if (cnt == 2'd3) begin
              state_n = S_HOLD;
              cnt_n   = 2'd0;
              pc_n    = fetch_pc;
              inst_n  = {mem_data_i, part};
              valid_n = 1'b1;
              req_n   = 1'b0;
              fill    = 1'b1;
            end else begin
              case (cnt)
                2'd0:    part_n[7:0]   = mem_data_i;
                2'd1:    part_n[15:8]  = mem_data_i;
                default: part_n[23:16] = mem_data_i;
              endcase
              cnt_n  = cnt + 2'd1;
              req_n  = 1'b1;
              addr_n = fetch_pc + {30'd0, cnt_n};
            end
          end else begin
            req_n  = 1'b1;
            addr_n = fetch_pc + {30'd0, cnt};
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            state_n    = S_FETCH;
            cnt_n      = 2'd0;
            fetch_pc_n = seq_pc;
            valid_n    = 1'b0;
            req_n      = !hit_seq;
            addr_n     = seq_pc;
          end
        end
        default: state_n = S_FETCH;
      endcase
    end
  end

  // State register; frozen while rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
    end else if (rdy) begin
      state <= state_n;
    end
  end

  // Datapath and output registers; frozen while rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= 2'd0;
      fetch_pc     <= RESET_PC;
      part         <= 24'h0;
      pc_o         <= 32'h0;
      inst_o       <= 32'h0;
      inst_valid_o <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= 32'h0;
    end else if (rdy) begin
      cnt          <= cnt_n;
      fetch_pc     <= fetch_pc_n;
      part         <= part_n;
      pc_o         <= pc_n;
      inst_o       <= inst_n;
      inst_valid_o <= valid_n;
      mem_req_o    <= req_n;
      mem_addr_o   <= addr_n;
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Testbench for stage_if: byte-memory responder plus per-scenario tasks.
// Expected {pc, inst} pairs are pushed when a fetch is started and popped when
// inst_valid_o is seen. Define ICACHE_EN to also exercise the icache.
module tb_stage_if;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        stall_i;
  logic        branch_enable_i;
  logic [31:0] branch_addr_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [7:0]  mem_data_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [31:0] addr_log[$];

  stage_if #(.RESET_PC(32'h0), .ICACHE_IDX_W(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_i(stall_i),
    .branch_enable_i(branch_enable_i), .branch_addr_i(branch_addr_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0:   return 8'h13;
      32'h1:   return 8'h05;
      32'h2:   return 8'hA0;
      32'h3:   return 8'h00;
      default: return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h3C;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  // Memory responder: acks every outstanding request and logs its address.
  always @(negedge clk) begin
    mem_ack_i  = mem_req_o;
    mem_data_i = mem_byte(mem_addr_o);
    if (mem_req_o) addr_log.push_back(mem_addr_o);
  end

  task automatic wait_valid(output bit timed_out);
    int n;
    n = 0;
    while (inst_valid_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    timed_out = (inst_valid_o !== 1'b1);
  endtask

  // Let IF/ID take the held instruction for exactly one cycle.
  task automatic consume();
    stall_i = 1'b0;
    @(negedge clk);
    stall_i = 1'b1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    branch_enable_i = 1'b1;
    branch_addr_i   = target;
    stall_i         = 1'b0;
    @(negedge clk);
    branch_enable_i = 1'b0;
    stall_i         = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_o, 32'h0); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected %h", inst_o, 32'h0); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_req_o); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected %h", mem_addr_o, 32'h0); end
  endtask

  task automatic test_basic();
    int cyc, first;
    logic [63:0] e;
    addr_log.delete();
    exp_q.push_back({32'h0, 32'h00A00513});
    rst = 1'b1;
    cyc = 0;
    first = -1;
    while (inst_valid_o !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_req_o === 1'b1 && first < 0) first = cyc;
    end
    checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL basic_timeout: got valid %b expected 1", inst_valid_o); end
    checks++; if (cyc - first != 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4 cycles after first request", cyc - first); end
    checks++; if (addr_log.size() != 4) begin errors++; $display("FAIL basic_nreq: got %0d expected 4", addr_log.size()); end
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      checks++;
      if (addr_log[i] !== 32'(i)) begin errors++; $display("FAIL basic_addr%0d: got %h expected %h", i, addr_log[i], 32'(i)); end
    end
    e = exp_q.pop_front();
    checks++; if (inst_o !== e[31:0]) begin errors++; $display("FAIL basic_inst: got %h expected %h", inst_o, e[31:0]); end
    checks++; if (pc_o !== e[63:32]) begin errors++; $display("FAIL basic_pc: got %h expected %h", pc_o, e[63:32]); end
  endtask

  task automatic test_stall();
    bit to;
    logic [63:0] e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (inst_valid_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'h00A00513 || mem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: got valid %b pc %h inst %h req %b expected 1 0 00a00513 0",
                 i, inst_valid_o, pc_o, inst_o, mem_req_o);
      end
    end
    exp_q.push_back({32'h4, exp_word(32'h4)});
    consume();
    checks++;
    if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h4) begin
      errors++;
      $display("FAIL stall_next: got valid %b req %b addr %h expected 0 1 00000004", inst_valid_o, mem_req_o, mem_addr_o);
    end
    wait_valid(to);
    checks++; if (to) begin errors++; $display("FAIL stall_timeout: got no inst_valid_o expected valid"); end
    e = exp_q.pop_front();
    checks++; if (pc_o !== e[63:32] || inst_o !== e[31:0]) begin errors++; $display("FAIL stall_fetch: got %h/%h expected %h/%h", pc_o, inst_o, e[63:32], e[31:0]); end
  endtask

  task automatic test_redirect();
    int cyc;
    bit to;
    logic [63:0] e;
    consume();
    cyc = 0;
    while (mem_addr_o !== 32'hA && cyc < 20) begin @(negedge clk); cyc++; end
    checks++; if (mem_addr_o !== 32'hA) begin errors++; $display("FAIL redir_setup: got addr %h expected 0000000a", mem_addr_o); end
    exp_q.push_back({32'h100, exp_word(32'h100)});
    do_redirect(32'h100);
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL redir_drop: got req %b expected 0", mem_req_o); end
    addr_log.delete();
    wait_valid(to);
    checks++; if (to) begin errors++; $display("FAIL redir_timeout: got no inst_valid_o expected valid"); end
    checks++; if (addr_log.size() != 4) begin errors++; $display("FAIL redir_nreq: got %0d expected 4", addr_log.size()); end
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      checks++;
      if (addr_log[i] !== 32'h100 + 32'(i)) begin errors++; $display("FAIL redir_addr%0d: got %h expected %h", i, addr_log[i], 32'h100 + 32'(i)); end
    end
    e = exp_q.pop_front();
    checks++; if (pc_o !== e[63:32] || inst_o !== e[31:0]) begin errors++; $display("FAIL redir_fetch: got %h/%h expected %h/%h", pc_o, inst_o, e[63:32], e[31:0]); end
  endtask

  task automatic test_branch_stalled();
    bit to;
    logic [63:0] e;
    addr_log.delete();
    exp_q.push_back({32'h104, exp_word(32'h104)});
    consume();
    branch_enable_i = 1'b1;
    branch_addr_i   = 32'h200;
    wait_valid(to);
    checks++; if (to) begin errors++; $display("FAIL bstall_timeout: got no inst_valid_o expected valid"); end
    checks++; if (addr_log.size() != 4) begin errors++; $display("FAIL bstall_nreq: got %0d expected 4", addr_log.size()); end
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      checks++;
      if (addr_log[i] !== 32'h104 + 32'(i)) begin errors++; $display("FAIL bstall_addr%0d: got %h expected %h", i, addr_log[i], 32'h104 + 32'(i)); end
    end
    e = exp_q.pop_front();
    checks++; if (pc_o !== e[63:32] || inst_o !== e[31:0]) begin errors++; $display("FAIL bstall_fetch: got %h/%h expected %h/%h", pc_o, inst_o, e[63:32], e[31:0]); end
    @(negedge clk);
    checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h104) begin errors++; $display("FAIL bstall_hold: got valid %b pc %h expected 1 00000104", inst_valid_o, pc_o); end
    branch_enable_i = 1'b0;
  endtask

  task automatic test_rdy();
    int cyc;
    bit to;
    logic [63:0] e;
    exp_q.push_back({32'h108, exp_word(32'h108)});
    consume();
    cyc = 0;
    while (mem_addr_o !== 32'h109 && cyc < 20) begin @(negedge clk); cyc++; end
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_addr_o !== 32'h109 || mem_req_o !== 1'b1 || inst_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL rdy_freeze%0d: got addr %h req %b valid %b expected 00000109 1 0", i, mem_addr_o, mem_req_o, inst_valid_o);
      end
    end
    rdy = 1'b1;
    wait_valid(to);
    checks++; if (to) begin errors++; $display("FAIL rdy_timeout: got no inst_valid_o expected valid"); end
    e = exp_q.pop_front();
    checks++; if (pc_o !== e[63:32] || inst_o !== e[31:0]) begin errors++; $display("FAIL rdy_fetch: got %h/%h expected %h/%h", pc_o, inst_o, e[63:32], e[31:0]); end
  endtask

  task automatic test_pc_wrap();
    bit to;
    logic [63:0] e;
    exp_q.push_back({32'hFFFFFFFC, exp_word(32'hFFFFFFFC)});
    do_redirect(32'hFFFFFFFC);
    checks++; if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin errors++; $display("FAIL wrap_redir_hold: got valid %b req %b expected 0 0", inst_valid_o, mem_req_o); end
    wait_valid(to);
    checks++; if (to) begin errors++; $display("FAIL wrap_timeout1: got no inst_valid_o expected valid"); end
    e = exp_q.pop_front();
    checks++; if (pc_o !== e[63:32] || inst_o !== e[31:0]) begin errors++; $display("FAIL wrap_top: got %h/%h expected %h/%h", pc_o, inst_o, e[63:32], e[31:0]); end
    exp_q.push_back({32'h0, 32'h00A00513});
    consume();
    wait_valid(to);
    checks++; if (to) begin errors++; $display("FAIL wrap_timeout2: got no inst_valid_o expected valid"); end
    e = exp_q.pop_front();
    checks++; if (pc_o !== e[63:32] || inst_o !== e[31:0]) begin errors++; $display("FAIL wrap_zero: got %h/%h expected %h/%h", pc_o, inst_o, e[63:32], e[31:0]); end
  endtask

  task automatic test_reset_misaligned();
    bit to;
    logic [63:0] e;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b0 || pc_o !== 32'h0) begin errors++; $display("FAIL rerst_state: got valid %b req %b pc %h expected 0 0 0", inst_valid_o, mem_req_o, pc_o); end
    rst = 1'b1;
    addr_log.delete();
    exp_q.push_back({32'h0, 32'h00A00513});
    wait_valid(to);
    checks++; if (to) begin errors++; $display("FAIL rerst_timeout: got no inst_valid_o expected valid"); end
    checks++; if (addr_log.size() != 4) begin errors++; $display("FAIL rerst_nreq: got %0d expected 4", addr_log.size()); end
    e = exp_q.pop_front();
    checks++; if (pc_o !== e[63:32] || inst_o !== e[31:0]) begin errors++; $display("FAIL rerst_fetch: got %h/%h expected %h/%h", pc_o, inst_o, e[63:32], e[31:0]); end
    exp_q.push_back({32'hFFFFFFFE, exp_word(32'hFFFFFFFE)});
    do_redirect(32'hFFFFFFFE);
    addr_log.delete();
    wait_valid(to);
    checks++; if (to) begin errors++; $display("FAIL mis_timeout: got no inst_valid_o expected valid"); end
    checks++; if (addr_log.size() != 4) begin errors++; $display("FAIL mis_nreq: got %0d expected 4", addr_log.size()); end
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      checks++;
      if (addr_log[i] !== 32'hFFFFFFFE + 32'(i)) begin errors++; $display("FAIL mis_addr%0d: got %h expected %h", i, addr_log[i], 32'hFFFFFFFE + 32'(i)); end
    end
    e = exp_q.pop_front();
    checks++; if (pc_o !== e[63:32] || inst_o !== e[31:0]) begin errors++; $display("FAIL mis_fetch: got %h/%h expected %h/%h", pc_o, inst_o, e[63:32], e[31:0]); end
  endtask

`ifdef ICACHE_EN
  task automatic test_icache();
    bit to;
    logic [63:0] e;
    exp_q.push_back({32'h20, exp_word(32'h20)});
    do_redirect(32'h20);
    wait_valid(to);
    checks++; if (to) begin errors++; $display("FAIL ic_fill_timeout: got no inst_valid_o expected valid"); end
    e = exp_q.pop_front();
    checks++; if (pc_o !== e[63:32] || inst_o !== e[31:0]) begin errors++; $display("FAIL ic_fill: got %h/%h expected %h/%h", pc_o, inst_o, e[63:32], e[31:0]); end
    exp_q.push_back({32'h20, exp_word(32'h20)});
    do_redirect(32'h20);
    addr_log.delete();
    checks++; if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL ic_enter: got req %b valid %b expected 0 0", mem_req_o, inst_valid_o); end
    @(negedge clk);
    checks++; if (inst_valid_o !== 1'b1 || mem_req_o !== 1'b0) begin errors++; $display("FAIL ic_hit: got valid %b req %b expected 1 0", inst_valid_o, mem_req_o); end
    checks++; if (addr_log.size() != 0) begin errors++; $display("FAIL ic_noreq: got %0d requests expected 0", addr_log.size()); end
    e = exp_q.pop_front();
    checks++; if (pc_o !== e[63:32] || inst_o !== e[31:0]) begin errors++; $display("FAIL ic_data: got %h/%h expected %h/%h", pc_o, inst_o, e[63:32], e[31:0]); end
  endtask
`endif

  initial begin
    rst             = 1'b0;
    rdy             = 1'b1;
    stall_i         = 1'b1;
    branch_enable_i = 1'b0;
    branch_addr_i   = 32'h0;
    mem_ack_i       = 1'b0;
    mem_data_i      = 8'h0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_branch_stalled();
    test_rdy();
    test_pc_wrap();
    test_reset_misaligned();
`ifdef ICACHE_EN
    test_icache();
`endif
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
